delay_line_update: RTL and testbench

DELAY_LINE_UPDATE -- requirements
Module: delay_line_update

---
 rtl/delay_line_update.sv | 157 +++++++++++++++
 tb/tb_delay_line_update.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/delay_line_update.sv
// Delay-line update block: captures a quantized difference (dq, sign-magnitude)
// and a reconstructed sample (sr, two's complement), converts both to the
// 11-bit float form {sign, exp[3:0], mant[5:0]} and pushes them into the
// DQ (6 deep) and SR (2 deep) delay lines with a one-cycle done pulse.
module delay_line_update (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dq,
    input  logic [15:0] sr,
    output logic [10:0] dq1,
    output logic [10:0] dq2,
    output logic [10:0] dq3,
    output logic [10:0] dq4,
    output logic [10:0] dq5,
    output logic [10:0] dq6,
    output logic [10:0] sr1,
    output logic [10:0] sr2,
    output logic        done,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLT_W   = 11;
    localparam int unsigned DQ_LEN  = 6;
    localparam int unsigned SR_LEN  = 2;
    localparam logic [FLT_W-1:0] FLT_ZERO = 11'h020;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CVT   = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] dq_in_q, dq_in_d;
    logic [DATA_W-1:0] sr_in_q, sr_in_d;
    logic [FLT_W-1:0]  dq0f_q, dq0f_d;
    logic [FLT_W-1:0]  sr0f_q, sr0f_d;
    logic [FLT_W-1:0]  dq_line_q [DQ_LEN];
    logic [FLT_W-1:0]  dq_line_d [DQ_LEN];
    logic [FLT_W-1:0]  sr_line_q [SR_LEN];
    logic [FLT_W-1:0]  sr_line_d [SR_LEN];
    logic              done_q, done_d;
    logic [14:0]       sr_mag_c;
    logic              unused_test_c;

    // Magnitude to float: exponent is leading-one position + 1, mantissa is
    // the normalised top six bits; zero magnitude maps to exp 0, mant 32.
    function automatic logic [FLT_W-1:0] to_float(input logic sgn, input logic [14:0] mag);
        logic [3:0]  e;
        logic [20:0] sh;
        e = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag[i]) e = 4'(i + 1);
        end
        sh = {mag, 6'b0} >> e;
        if (mag == 15'd0) return {sgn, 4'd0, 6'd32};
        return {sgn, e, sh[5:0]};
    endfunction

    // Two's complement magnitude of sr, folded to 15 bits (0x8000 -> 0).
    assign sr_mag_c = sr_in_q[15] ? 15'(~sr_in_q + 16'd1) : sr_in_q[14:0];

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        dq_in_d   = dq_in_q;
        sr_in_d   = sr_in_q;
        dq0f_d    = dq0f_q;
        sr0f_d    = sr0f_q;
        dq_line_d = dq_line_q;
        sr_line_d = sr_line_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dq_in_d = dq;
                    sr_in_d = sr;
                    state_d = S_CVT;
                end
            end
            S_CVT: begin
                dq0f_d  = to_float(dq_in_q[15], dq_in_q[14:0]);
                sr0f_d  = to_float(sr_in_q[15], sr_mag_c);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                for (int i = DQ_LEN - 1; i > 0; i--) dq_line_d[i] = dq_line_q[i-1];
                dq_line_d[0] = dq0f_q;
                sr_line_d[1] = sr_line_q[0];
                sr_line_d[0] = sr0f_q;
                done_d       = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dq_in_q <= '0;
            sr_in_q <= '0;
            dq0f_q  <= '0;
            sr0f_q  <= '0;
            for (int i = 0; i < DQ_LEN; i++) dq_line_q[i] <= FLT_ZERO;
            for (int i = 0; i < SR_LEN; i++) sr_line_q[i] <= FLT_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dq_in_q   <= dq_in_d;
            sr_in_q   <= sr_in_d;
            dq0f_q    <= dq0f_d;
            sr0f_q    <= sr0f_d;
            dq_line_q <= dq_line_d;
            sr_line_q <= sr_line_d;
            done_q    <= done_d;
        end
    end

    assign dq1  = dq_line_q[0];
    assign dq2  = dq_line_q[1];
    assign dq3  = dq_line_q[2];
    assign dq4  = dq_line_q[3];
    assign dq5  = dq_line_q[4];
    assign dq6  = dq_line_q[5];
    assign sr1  = sr_line_q[0];
    assign sr2  = sr_line_q[1];
    assign done = done_q;

    // Test hooks are not functional.
    assign unused_test_c = &{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

endmodule

// File: tb/tb_delay_line_update.sv
// Directed self-checking bench for delay_line_update.
module tb_delay_line_update;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dq, sr;
    logic [10:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;
    logic        done;
    logic        so0, so1, so2, so3, so4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_line_update dut (
        .clk(clk), .reset(reset), .start(start), .dq(dq), .sr(sr),
        .dq1(dq1), .dq2(dq2), .dq3(dq3), .dq4(dq4), .dq5(dq5), .dq6(dq6),
        .sr1(sr1), .sr2(sr2), .done(done),
        .scan_in0(1'b0), .scan_in1(1'b1), .scan_in2(1'b0), .scan_in3(1'b1),
        .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3),
        .scan_out4(so4)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with start pulsed for one edge; checks done timing.
    task automatic do_op(input logic [15:0] d, input logic [15:0] s);
        start = 1'b1; dq = d; sr = s;
        tick();                          // E0
        start = 1'b0;
        dq = 16'h1234; sr = 16'h4321;    // must not affect the capture
        tick();                          // E1
        check_eq("done_e1", 16'(done), 16'h0);
        tick();                          // E2
        check_eq("done_e2", 16'(done), 16'h1);
        tick();                          // E3
        check_eq("done_e3", 16'(done), 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'($urandom_range(1));
        dq = 16'($urandom); sr = 16'($urandom);
        tick();
        dq = 16'($urandom); sr = 16'($urandom);
        tick();
        reset = 1'b0; start = 1'b0;
    endtask

    int dcnt;
    int n;

    initial begin
        reset = 1'b1; start = 1'b0; dq = '0; sr = '0;

        // Reset state
        do_reset();
        check_eq("rst_dq1", 16'(dq1), 16'h020);
        check_eq("rst_dq2", 16'(dq2), 16'h020);
        check_eq("rst_dq3", 16'(dq3), 16'h020);
        check_eq("rst_dq4", 16'(dq4), 16'h020);
        check_eq("rst_dq5", 16'(dq5), 16'h020);
        check_eq("rst_dq6", 16'(dq6), 16'h020);
        check_eq("rst_sr1", 16'(sr1), 16'h020);
        check_eq("rst_sr2", 16'(sr2), 16'h020);
        check_eq("rst_done", 16'(done), 16'h0);
        check_eq("scan_out", 16'({so0, so1, so2, so3, so4}), 16'h0);

        // Zero and sign cases
        do_op(16'h0000, 16'h0000);
        check_eq("zero_dq1", 16'(dq1), 16'h020);
        check_eq("zero_sr1", 16'(sr1), 16'h020);
        do_op(16'h8005, 16'hFFFB);
        check_eq("neg5_dq1", 16'(dq1), 16'h4E8);
        check_eq("neg5_sr1", 16'(sr1), 16'h4E8);
        check_eq("neg5_dq2", 16'(dq2), 16'h020);
        check_eq("neg5_sr2", 16'(sr2), 16'h020);

        // Full-scale boundaries
        do_op(16'h7FFF, 16'h8000);
        check_eq("full_dq1", 16'(dq1), 16'h3FF);
        check_eq("full_sr1", 16'(sr1), 16'h420);
        check_eq("full_dq2", 16'(dq2), 16'h4E8);
        do_op(16'h0001, 16'h0001);
        check_eq("one_dq1", 16'(dq1), 16'h060);
        check_eq("one_sr1", 16'(sr1), 16'h060);
        check_eq("one_dq2", 16'(dq2), 16'h3FF);
        check_eq("one_sr2", 16'(sr2), 16'h420);

        // Shift depth: magnitudes 1..64
        for (int i = 0; i < 7; i++) begin
            do_op(16'(1 << i), 16'(1 << i));
        end
        check_eq("depth_dq1", 16'(dq1), 16'h1E0);
        check_eq("depth_dq2", 16'(dq2), 16'h1A0);
        check_eq("depth_dq3", 16'(dq3), 16'h160);
        check_eq("depth_dq4", 16'(dq4), 16'h120);
        check_eq("depth_dq5", 16'(dq5), 16'h0E0);
        check_eq("depth_dq6", 16'(dq6), 16'h0A0);
        check_eq("depth_sr1", 16'(sr1), 16'h1E0);
        check_eq("depth_sr2", 16'(sr2), 16'h1A0);

        // Handshake: start held high gives one operation
        do_reset();
        start = 1'b1; dq = 16'h0001; sr = 16'h0001;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dcnt++;
        end
        check_eq("hold_done_cnt", 16'(dcnt), 16'd1);
        check_eq("hold_dq1", 16'(dq1), 16'h060);
        check_eq("hold_dq2", 16'(dq2), 16'h020);
        start = 1'b0;
        tick();
        start = 1'b1; dq = 16'h7FFF; sr = 16'h8000;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (done) break;
        end
        check_eq("resample_lat", 16'(n), 16'd3);
        start = 1'b0;
        tick();
        check_eq("resample_dq1", 16'(dq1), 16'h3FF);
        check_eq("resample_dq2", 16'(dq2), 16'h060);
        tick();

        // Mid-operation reset aborts with no shift
        do_reset();
        start = 1'b1; dq = 16'h7FFF; sr = 16'h8000;
        tick();                          // E0
        start = 1'b0;
        reset = 1'b1;
        tick();                          // reset during CVT
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        check_eq("abort_done_cnt", 16'(dcnt), 16'd0);
        check_eq("abort_dq1", 16'(dq1), 16'h020);
        check_eq("abort_sr1", 16'(sr1), 16'h020);

        // Inputs changed during CVT must not matter
        start = 1'b1; dq = 16'h8005; sr = 16'hFFFB;
        tick();                          // E0
        start = 1'b0; dq = 16'h7FFF; sr = 16'h8000;
        tick();
        tick();
        check_eq("hold_in_done", 16'(done), 16'h1);
        check_eq("hold_in_dq1", 16'(dq1), 16'h4E8);
        check_eq("hold_in_sr1", 16'(sr1), 16'h4E8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
